// File: rtl/encode_upperimm_writer_pkg.sv
// Shared processor defines: opcodes, NOP word, ALU operation codes and the
// writer FSM state encoding.
package encode_upperimm_writer_pkg;

  localparam logic [6:0]  OPC_LUI   = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC = 7'b0010111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_LUI   = 5'd14;
  localparam logic [4:0] ALU_AUIPC = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } wr_state_t;

endpackage

// File: rtl/encode_upperimm_writer_if.sv
// Instruction-field handshake plus instruction-memory write bus.
interface encode_upperimm_writer_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic [4:0]  alu_control;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;

  modport slave (
    input  in_valid, rd, imm, alu_control, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, rd, imm, alu_control, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/encode_upperimm_writer_encode.sv
// Combinational field-to-word encoder for upper-immediate instructions.
// Anything that is not LUI/AUIPC/NOP becomes a NOP and is flagged.
module encode_upperimm_inst
  import encode_upperimm_writer_pkg::*;
(
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [4:0]  alu_control,
  output logic [31:0] word,
  output logic        imm_dropped,
  output logic        op_bad
);

  // imm[11:0] cannot be represented in a U-type word; report when it is lost
  always_comb begin
    word        = NOP_WORD;
    imm_dropped = 1'b0;
    op_bad      = 1'b0;
    case (alu_control)
      ALU_LUI: begin
        word        = {imm[31:12], rd, OPC_LUI};
        imm_dropped = |imm[11:0];
      end
      ALU_AUIPC: begin
        word        = {imm[31:12], rd, OPC_AUIPC};
        imm_dropped = |imm[11:0];
      end
      ALU_NOP: word = NOP_WORD;
      default: op_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/encode_upperimm_writer.sv
// Program-load writer: accepts instruction fields, encodes them and writes
// the words to consecutive instruction-memory addresses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; job parameters latched on start
// ST_ACCEPT | in_ready high, waiting for one set of instruction fields
// ST_WRITE  | mem_we high with stable addr/data until mem_ack
// ST_DONE   | one-cycle done pulse, then back to idle
module encode_upperimm_writer
  import encode_upperimm_writer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] num_words,
  encode_upperimm_writer_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic        err_imm,
  output logic        err_op,
  output logic [15:0] words_written
);

  wr_state_t   state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [15:0] num_q, count_q, count_inc;
  logic        err_imm_q, err_op_q;
  logic [31:0] enc_word;
  logic        enc_imm_dropped, enc_op_bad;

  encode_upperimm_inst u_encode (
    .rd          (bus.rd),
    .imm         (bus.imm),
    .alu_control (bus.alu_control),
    .word        (enc_word),
    .imm_dropped (enc_imm_dropped),
    .op_bad      (enc_op_bad)
  );

  assign count_inc = count_q + 16'd1;

  // next-state decode; handshake/status outputs depend on state only
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (num_words == 16'd0) ? ST_DONE : ST_ACCEPT;
      end
      ST_ACCEPT: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        bus.mem_we = 1'b1;
        if (bus.mem_ack) state_nxt = (count_inc == num_q) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register; reset abandons any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // job parameters, write address/data, progress count and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      num_q     <= 16'd0;
      count_q   <= 16'd0;
      err_imm_q <= 1'b0;
      err_op_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            num_q     <= num_words;
            count_q   <= 16'd0;
            err_imm_q <= 1'b0;
            err_op_q  <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (bus.in_valid) begin
            wdata_q   <= enc_word;
            err_imm_q <= err_imm_q | enc_imm_dropped;
            err_op_q  <= err_op_q | enc_op_bad;
          end
        end
        ST_WRITE: begin
          if (bus.mem_ack) begin
            addr_q  <= addr_q + 32'd4;
            count_q <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign words_written = count_q;
  assign err_imm       = err_imm_q;
  assign err_op        = err_op_q;

endmodule

// File: tb/tb_encode_upperimm_writer.sv
// Scoreboard bench for encode_upperimm_writer: the driver pushes expected
// writes/job results, the monitor pops and compares on each ack/done.
module tb_encode_upperimm_writer;
  import encode_upperimm_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] num_words = 16'd0;
  logic        busy, done, err_imm, err_op;
  logic [15:0] words_written;

  encode_upperimm_writer_if bus();

  encode_upperimm_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .err_imm       (err_imm),
    .err_op        (err_op),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] word; } wr_t;
  typedef struct { logic [15:0] ww; logic ei; logic eo; } job_t;

  wr_t  exp_q[$];
  job_t job_q[$];
  int   n_cmp = 0, n_err = 0;
  int   done_seen = 0, we_total = 0, last_we_len = 0;
  bit   ack_rand = 1'b0;
  int   hold_cycles = 0;
  int   low_cnt = 0;

  logic [4:0]  j_rd[16];
  logic [31:0] j_imm[16];
  logic [4:0]  j_op[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  // Reference: U-type word = upper 20 immediate bits, rd at bit 7, opcode.
  function automatic logic [31:0] ref_word(input logic [4:0] rd, input logic [31:0] imm,
                                           input logic [4:0] op);
    if (op == ALU_LUI)   return (imm & 32'hFFFF_F000) + (32'(rd) * 32'd128) + 32'h37;
    if (op == ALU_AUIPC) return (imm & 32'hFFFF_F000) + (32'(rd) * 32'd128) + 32'h17;
    return 32'h13;
  endfunction

  // memory responder: optional forced stall at the start of each write
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!bus.mem_we) begin
        low_cnt = hold_cycles;
        bus.mem_ack = ack_rand && ($urandom_range(0, 1) == 1);
      end else if (low_cnt > 0) begin
        bus.mem_ack = 1'b0;
        low_cnt--;
      end else begin
        bus.mem_ack = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [31:0] prev_addr, prev_wdata;
    bit prev_we, prev_ack, prev_done;
    int we_len;
    wr_t w;
    job_t e;
    prev_addr = 0; prev_wdata = 0; prev_we = 0; prev_ack = 0; prev_done = 0; we_len = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_we = 0; prev_ack = 0; prev_done = 0; we_len = 0;
      end else begin
        if (prev_we && !prev_ack) begin
          chk("we_held", 32'(bus.mem_we), 32'd1);
          chk("addr_stable", bus.mem_addr, prev_addr);
          chk("wdata_stable", bus.mem_wdata, prev_wdata);
        end
        if (bus.mem_we) begin
          we_total++;
          we_len++;
          chk("in_ready_in_write", 32'(bus.in_ready), 32'd0);
          chk("busy_in_write", 32'(busy), 32'd1);
          if (bus.mem_ack) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_write: addr %h data %h", bus.mem_addr, bus.mem_wdata);
            end else begin
              w = exp_q.pop_front();
              chk("mem_addr", bus.mem_addr, w.addr);
              chk("mem_wdata", bus.mem_wdata, w.word);
            end
            last_we_len = we_len;
            we_len = 0;
          end
        end
        if (done) begin
          chk("done_one_cycle", 32'(prev_done), 32'd0);
          chk("we_low_at_done", 32'(bus.mem_we), 32'd0);
          if (job_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: words_written %0d", words_written);
          end else begin
            e = job_q.pop_front();
            chk("done_words_written", 32'(words_written), 32'(e.ww));
            chk("done_err_imm", 32'(err_imm), 32'(e.ei));
            chk("done_err_op", 32'(err_op), 32'(e.eo));
          end
          done_seen++;
        end
        prev_we    = bus.mem_we;
        prev_ack   = bus.mem_ack;
        prev_done  = done;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
      end
    end
  end

  task automatic send_word(input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] op);
    int t = 0;
    if (ack_rand) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1; bus.rd = rd; bus.imm = imm; bus.alu_control = op;
    @(negedge clk);
    while (!bus.in_ready && t < 500) begin @(negedge clk); t++; end
    if (!bus.in_ready) timeout_fail("in_ready_wait");
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.rd = 5'($urandom); bus.imm = $urandom; bus.alu_control = 5'($urandom);
  endtask

  task automatic wait_done(input int t0);
    int t = 0;
    while (done_seen == t0 && t < 2000) begin @(negedge clk); t++; end
    if (done_seen == t0) timeout_fail("done_wait");
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input bit junk_start);
    job_t j;
    logic [31:0] a;
    int t0;
    j.ww = 16'(n); j.ei = 1'b0; j.eo = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ((j_op[i] == ALU_LUI || j_op[i] == ALU_AUIPC) && j_imm[i][11:0] != 12'd0) j.ei = 1'b1;
      if (j_op[i] != ALU_LUI && j_op[i] != ALU_AUIPC && j_op[i] != ALU_NOP) j.eo = 1'b1;
    end
    job_q.push_back(j);
    t0 = done_seen;
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; num_words = 16'($urandom);
    if (junk_start && n > 0) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    a = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: a, word: ref_word(j_rd[i], j_imm[i], j_op[i])});
      a = a + 32'd4;
      send_word(j_rd[i], j_imm[i], j_op[i]);
    end
    wait_done(t0);
    @(negedge clk);
    chk("hold_words_written", 32'(words_written), 32'(n));
    chk("hold_err_imm", 32'(err_imm), 32'(j.ei));
    chk("hold_err_op", 32'(err_op), 32'(j.eo));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_before, t, r;
    bus.in_valid = 1'b0; bus.rd = 5'd0; bus.imm = 32'd0; bus.alu_control = 5'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_words", 32'(words_written), 32'd0);
    chk("rst_errs", {30'd0, err_imm, err_op}, 32'd0);
    #2 rst_n = 1'b1;

    // single LUI
    j_rd[0] = 5'd5; j_imm[0] = 32'h1234_5000; j_op[0] = ALU_LUI;
    run_job(32'h100, 1, 1'b1);

    // AUIPC with all-ones upper immediate
    j_rd[0] = 5'd1; j_imm[0] = 32'hFFFF_F000; j_op[0] = ALU_AUIPC;
    run_job(32'h200, 1, 1'b0);

    // memory stalls three cycles
    hold_cycles = 3;
    j_rd[0] = 5'd9; j_imm[0] = 32'hCAFE_B000; j_op[0] = ALU_LUI;
    run_job(32'h400, 1, 1'b0);
    chk("stall_we_len", 32'(last_we_len), 32'd4);
    hold_cycles = 0;

    // dropped low immediate bits and unsupported op
    j_rd[0] = 5'd0; j_imm[0] = 32'h0000_1234; j_op[0] = ALU_LUI;
    j_rd[1] = 5'd3; j_imm[1] = 32'h5555_5000; j_op[1] = ALU_OR;
    run_job(32'h800, 2, 1'b0);

    // address wrap
    j_rd[0] = 5'd31; j_imm[0] = 32'h8000_0000; j_op[0] = ALU_AUIPC;
    j_rd[1] = 5'd2;  j_imm[1] = 32'h0;         j_op[1] = ALU_NOP;
    run_job(32'hFFFF_FFFC, 2, 1'b0);

    // empty job
    we_before = we_total;
    run_job(32'h1000, 0, 1'b0);
    chk("empty_no_we", 32'(we_total - we_before), 32'd0);

    // reset while a write is stalled
    hold_cycles = 1000;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h2000; num_words = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send_word(5'd4, 32'hABCD_E123, ALU_LUI);
    t = 0;
    @(negedge clk);
    while (!bus.mem_we && t < 50) begin @(negedge clk); t++; end
    if (!bus.mem_we) timeout_fail("abort_we_wait");
    chk("abort_pre_err_imm", 32'(err_imm), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_err_imm", 32'(err_imm), 32'd0);
    chk("abort_words", 32'(words_written), 32'd0);
    chk("abort_addr", bus.mem_addr, 32'd0);
    chk("abort_wdata", bus.mem_wdata, 32'd0);
    hold_cycles = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    j_rd[0] = 5'd7; j_imm[0] = 32'hABCD_E000; j_op[0] = ALU_LUI;
    run_job(32'h300, 1, 1'b0);

    // randomized jobs with random memory back-pressure
    ack_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int n;
      logic [31:0] base;
      n = $urandom_range(1, 6);
      base = (k % 5 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                          : ($urandom & 32'hFFFF_FFFC);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        j_rd[i]  = 5'($urandom);
        j_imm[i] = $urandom;
        if ($urandom_range(0, 1) == 1) j_imm[i] = j_imm[i] & 32'hFFFF_F000;
        if (r < 4)       j_op[i] = ALU_LUI;
        else if (r < 7)  j_op[i] = ALU_AUIPC;
        else if (r == 7) j_op[i] = ALU_NOP;
        else begin
          j_op[i] = 5'($urandom);
          if (j_op[i] == ALU_LUI || j_op[i] == ALU_AUIPC || j_op[i] == ALU_NOP) j_op[i] = ALU_ADD;
        end
      end
      run_job(base, n, k[0]);
    end

    chk("writes_all_seen", 32'(exp_q.size()), 32'd0);
    chk("jobs_all_done", 32'(job_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
